fetch_pc_unit: RTL
==================

# fetch_pc_unit

Instruction-fetch PC generator that sits directly upstream of the branch prediction unit in the pipelined core. It holds the fetch PC and supplies it to the predictor. A direct-mapped branch target buffer (BTB) provides predicted targets; the unit combines the predictor's taken/not-taken bit with BTB hits to choose the next PC. It also detects mispredictions reported from EX, redirects fetch, and raises a flush for the IF/ID pipeline registers.

## Interface
Parameters:
- PC_WIDTH, 8, fetch address width; PC wraps modulo 2^PC_WIDTH.
- BTB_IDX, 4, BTB index width; 2^BTB_IDX entries, tag = pc[PC_WIDTH-1:BTB_IDX].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- stall  in  1  hazard stall; PC holds when high.
- prediction  in  1  taken/not-taken bit from the branch predictor for the current pc.
- ex_branch  in  1  a branch is resolving in EX this cycle.
- ex_taken  in  1  actual outcome of the EX branch.
- ex_pred_taken  in  1  predicted-taken flag carried down with the EX branch.
- ex_pc  in  PC_WIDTH  address of the EX branch.
- ex_target  in  PC_WIDTH  computed target of the EX branch.
- ex_pred_target  in  PC_WIDTH  predicted target carried down with the EX branch.
- pc  out  PC_WIDTH  current fetch PC (registered).
- pc_plus1  out  PC_WIDTH  pc + 1, truncated.
- pred_taken  out  1  fetch redirected by prediction this cycle; carried down the pipeline.
- pred_target  out  PC_WIDTH  BTB target on hit, else pc_plus1; carried down the pipeline.
- flush  out  1  misprediction detected; squash IF/ID contents.
- mispredict_count  out  8  saturating count of mispredictions.

## Operation
BTB:
- Each entry holds valid, tag (PC_WIDTH-BTB_IDX bits) and target (PC_WIDTH bits).
- Lookup is combinational at index pc[BTB_IDX-1:0].
- btb_hit = valid & (tag == pc[PC_WIDTH-1:BTB_IDX]).

Prediction:
- pred_taken = prediction & btb_hit & ~stall.
- pred_target = btb_hit ? BTB target : pc_plus1.

Misprediction (combinational):
- mispredict = ex_branch & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_pred_target != ex_target)).
- flush = mispredict.
- Corrected PC = ex_taken ? ex_target : ex_pc + 1 (truncated).

Next-PC priority, highest first:
1. mispredict → corrected PC (overrides stall).
2. stall → hold pc.
3. pred_taken → BTB target.
4. otherwise → pc_plus1.

BTB update, at the clock edge:
- When ex_branch & ex_taken, write entry at ex_pc index: valid=1, tag from ex_pc, target=ex_target.
- Not-taken branches do not modify the BTB.

Mispredict counter:
- Increments on each cycle with mispredict=1.
- Saturates at 8'hFF.

Arithmetic:
- All PC adds are modulo 2^PC_WIDTH; 8'hFF + 1 = 8'h00, with no carry output.

## Timing
- Reset (async assert): pc=0, all BTB valid=0, mispredict_count=0. Outputs then settle to pc_plus1=1, pred_taken=0, pred_target=1, flush=0 (given ex_branch=0).
- pc changes one cycle after the next-PC decision.
- flush is high in the same cycle as the EX branch; the corrected pc appears at the next edge.
- BTB read and write to the same index in the same cycle: the read returns the old contents; the new entry is visible the next cycle.
- mispredict during stall: pc loads the corrected PC; stall is ignored for that cycle.
- Reset mid-operation: all state clears immediately; no partial BTB write completes.
- The BPU samples pc; prediction must be valid combinationally within the same cycle.

## Test plan
- Reset then free run, stall=0, prediction=0, ex_branch=0 → pc sequence 0,1,2,…; after 8'hFF, pc=8'h00.
- Branch at ex_pc=8'h05, ex_taken=1, ex_target=8'h20, ex_pred_taken=0 → flush=1 that cycle, next pc=8'h20, BTB[5] valid with target 8'h20, mispredict_count=1.
- Then pc reaches 8'h05 with prediction=1 → pred_taken=1, pred_target=8'h20, next pc=8'h20, flush=0.
- pc=8'h15 (same index as 8'h05, different tag) with prediction=1 → btb_hit=0, pred_taken=0, next pc=8'h16.
- stall=1 and a simultaneous mispredict: ex_pc=8'h30, ex_taken=0, ex_pred_taken=1 → pc loads 8'h31; with stall alone the next cycle, pc holds 8'h31.
- Force 260 mispredictions → mispredict_count=8'hFF and holds; assert reset mid-run → count=0, pc=0, all BTB entries miss.

Source files
------------

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Fetch PC generator with direct-mapped BTB, next-PC selection,
//            EX misprediction redirect/flush and saturating mispredict count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
   parameter int PC_WIDTH = 8,
   parameter int BTB_IDX  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                prediction,
   input  logic                ex_branch,
   input  logic                ex_taken,
   input  logic                ex_pred_taken,
   input  logic [PC_WIDTH-1:0] ex_pc,
   input  logic [PC_WIDTH-1:0] ex_target,
   input  logic [PC_WIDTH-1:0] ex_pred_target,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] pc_plus1,
   output logic                pred_taken,
   output logic [PC_WIDTH-1:0] pred_target,
   output logic                flush,
   output logic [7:0]          mispredict_count
);

   localparam int                  c_ENTRIES  = 1 << BTB_IDX;
   localparam int                  c_TAG_W    = PC_WIDTH - BTB_IDX;
   localparam logic [PC_WIDTH-1:0] c_PC_ONE   = PC_WIDTH'(1);
   localparam logic [7:0]          c_CNT_MAX  = 8'hFF;

   logic [PC_WIDTH-1:0] r_pc;
   logic [7:0]          r_mispredict_count;
   logic [c_ENTRIES-1:0] r_btb_valid;
   logic [c_TAG_W-1:0]  r_btb_tag    [c_ENTRIES];
   logic [PC_WIDTH-1:0] r_btb_target [c_ENTRIES];

   logic [PC_WIDTH-1:0] w_pc_plus1;
   logic [BTB_IDX-1:0]  w_rd_idx;
   logic [c_TAG_W-1:0]  w_rd_tag;
   logic                w_btb_hit;
   logic [PC_WIDTH-1:0] w_btb_target;
   logic                w_pred_taken;
   logic [PC_WIDTH-1:0] w_pred_target;
   logic                w_wrong_dir;
   logic                w_wrong_target;
   logic                w_mispredict;
   logic [PC_WIDTH-1:0] w_ex_pc_plus1;
   logic [PC_WIDTH-1:0] w_corrected_pc;
   logic                w_btb_write;
   logic [BTB_IDX-1:0]  w_wr_idx;
   logic [c_TAG_W-1:0]  w_wr_tag;
   logic [PC_WIDTH-1:0] w_next_pc;

   // BTB lookup on the current fetch PC
   assign w_pc_plus1    = r_pc + c_PC_ONE;
   assign w_rd_idx      = r_pc[BTB_IDX-1:0];
   assign w_rd_tag      = r_pc[PC_WIDTH-1:BTB_IDX];
   assign w_btb_hit     = r_btb_valid[w_rd_idx] && (r_btb_tag[w_rd_idx] == w_rd_tag);
   assign w_btb_target  = r_btb_target[w_rd_idx];

   assign w_pred_taken  = prediction && w_btb_hit && !stall;
   assign w_pred_target = w_btb_hit ? w_btb_target : w_pc_plus1;

   // Wrong target only matters when both actual and predicted said taken
   assign w_wrong_dir    = (ex_taken != ex_pred_taken);
   assign w_wrong_target = ex_taken && ex_pred_taken && (ex_pred_target != ex_target);
   assign w_mispredict   = ex_branch && (w_wrong_dir || w_wrong_target);
   assign w_ex_pc_plus1  = ex_pc + c_PC_ONE;
   assign w_corrected_pc = ex_taken ? ex_target : w_ex_pc_plus1;

   assign w_btb_write = ex_branch && ex_taken;
   assign w_wr_idx    = ex_pc[BTB_IDX-1:0];
   assign w_wr_tag    = ex_pc[PC_WIDTH-1:BTB_IDX];

   always_comb begin
      w_next_pc = w_pc_plus1;
      if (w_mispredict) begin
         w_next_pc = w_corrected_pc;
      end else if (stall) begin
         w_next_pc = r_pc;
      end else if (w_pred_taken) begin
         w_next_pc = w_btb_target;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= '0;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   // Read-before-write: lookup sees old contents in the cycle of an update
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < c_ENTRIES; i++) begin
            r_btb_valid[i]  <= 1'b0;
            r_btb_tag[i]    <= '0;
            r_btb_target[i] <= '0;
         end
      end else if (w_btb_write) begin
         r_btb_valid[w_wr_idx]  <= 1'b1;
         r_btb_tag[w_wr_idx]    <= w_wr_tag;
         r_btb_target[w_wr_idx] <= ex_target;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mispredict_count <= '0;
      end else if (w_mispredict && (r_mispredict_count != c_CNT_MAX)) begin
         r_mispredict_count <= r_mispredict_count + 8'd1;
      end
   end

   assign pc               = r_pc;
   assign pc_plus1         = w_pc_plus1;
   assign pred_taken       = w_pred_taken;
   assign pred_target      = w_pred_target;
   assign flush            = w_mispredict;
   assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire
